// File: rtl/ai_host_master_if.sv
// Register bus between the targeting-accelerator host master and the accelerator.
// 4-bit address, 32-bit data, separate read/write strobes, wait_request back-pressure.
interface ai_host_master_if;
  logic [3:0]  addr;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        wait_request;

  modport master (
    output addr,
    output write_en,
    output read_en,
    output data_out,
    input  data_in,
    input  wait_request
  );

  modport slave (
    input  addr,
    input  write_en,
    input  read_en,
    input  data_out,
    output data_in,
    output wait_request
  );
endinterface

// File: rtl/ai_host_master.sv
// Host-side bus master for the targeting accelerator.
// Latches one board snapshot, programs accelerator regs 1..9, kicks off the
// computation with a write to reg 0, waits for it and reads the shot index back.
// Optional feature macro: AI_HOST_READBACK_VERIFY_EN (reads regs 1..9 back and
// aborts before the start command on the first mismatch).
module ai_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned BOARD_CELLS    = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [99:0]             fired_in,
  input  logic [99:0]             hits_in,
  input  logic [4:0]              ships_in,
  output logic                    shot_valid,
  output logic [6:0]              shot_index,
  output logic                    shot_error,
  output logic                    timeout,
  ai_host_master_if.master        bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWrRegs,
    StRdVerify,
    StWrStart,
    StWaitBusy,
    StRdResult,
    StDone
  } state_e;

  localparam logic [11:0] TimeoutLast = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]  BadIndex    = 7'h7F;

  state_e      state_q, state_d;
  logic [3:0]  reg_idx_q, reg_idx_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [6:0]  shot_index_q, shot_index_d;
  logic        shot_error_q, shot_error_d;
  logic        timeout_q, timeout_d;
  logic [99:0] fired_q, hits_q;
  logic [4:0]  ships_q;

  logic        accept;
  logic [3:0]  addr_c;
  logic        we_c, re_c;
  logic [31:0] wdata_c;
  logic        stall;
  logic [31:0] reg_word;
  logic [127:0] fired_ext;
  logic        rd_bad;

  // Snapshot word that belongs in register reg_idx_q (regs 1..4 fired, 5..8 hits, 9 ships).
  always_comb begin
    reg_word = 32'd0;
    case (reg_idx_q)
      4'd1:    reg_word = fired_q[31:0];
      4'd2:    reg_word = fired_q[63:32];
      4'd3:    reg_word = fired_q[95:64];
      4'd4:    reg_word = {28'd0, fired_q[99:96]};
      4'd5:    reg_word = hits_q[31:0];
      4'd6:    reg_word = hits_q[63:32];
      4'd7:    reg_word = hits_q[95:64];
      4'd8:    reg_word = {28'd0, hits_q[99:96]};
      4'd9:    reg_word = {27'd0, ships_q};
      default: reg_word = 32'd0;
    endcase
  end

  // Zero-extended so any 7-bit index is in range; cells >= 100 read as not fired.
  assign fired_ext = {28'd0, fired_q};
  assign rd_bad    = (bus.data_in[31:7] != 25'd0)
                  || ({25'd0, bus.data_in[6:0]} >= BOARD_CELLS)
                  || fired_ext[bus.data_in[6:0]];

  // Next-state, bus strobes and result capture.
  always_comb begin
    state_d      = state_q;
    reg_idx_d    = reg_idx_q;
    wait_cnt_d   = 2'd0;
    shot_index_d = shot_index_q;
    shot_error_d = shot_error_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    addr_c       = 4'd0;
    we_c         = 1'b0;
    re_c         = 1'b0;
    wdata_c      = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept       = 1'b1;
          state_d      = StWrRegs;
          reg_idx_d    = 4'd1;
          shot_error_d = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      StWrRegs: begin
        addr_c  = reg_idx_q;
        we_c    = 1'b1;
        wdata_c = reg_word;
        if (!bus.wait_request) begin
          if (reg_idx_q == 4'd9) begin
`ifdef AI_HOST_READBACK_VERIFY_EN
            state_d   = StRdVerify;
            reg_idx_d = 4'd1;
`else
            state_d   = StWrStart;
`endif
          end else begin
            reg_idx_d = reg_idx_q + 4'd1;
          end
        end
      end
      StRdVerify: begin
`ifdef AI_HOST_READBACK_VERIFY_EN
        addr_c = reg_idx_q;
        re_c   = 1'b1;
        if (!bus.wait_request) begin
          if (bus.data_in != reg_word) begin
            // Accelerator holds a corrupt snapshot: never start it.
            state_d      = StDone;
            shot_error_d = 1'b1;
            timeout_d    = 1'b0;
            shot_index_d = BadIndex;
          end else if (reg_idx_q == 4'd9) begin
            state_d = StWrStart;
          end else begin
            reg_idx_d = reg_idx_q + 4'd1;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StWrStart: begin
        addr_c = 4'd0;
        we_c   = 1'b1;
        if (!bus.wait_request) begin
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        // Busy seen (or never raised within 4 cycles): the result read itself
        // stalls until the accelerator drops wait_request.
        if (bus.wait_request || wait_cnt_q == 2'd3) begin
          state_d = StRdResult;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      StRdResult: begin
        addr_c = 4'd0;
        re_c   = 1'b1;
        if (!bus.wait_request) begin
          state_d   = StDone;
          timeout_d = 1'b0;
          if (rd_bad) begin
            shot_error_d = 1'b1;
            shot_index_d = BadIndex;
          end else begin
            shot_error_d = 1'b0;
            shot_index_d = bus.data_in[6:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    stall = (we_c | re_c) & bus.wait_request;

    // Abort: strobes drop because the next state is DONE.
    if (stall && cnt_q == TimeoutLast) begin
      state_d      = StDone;
      shot_error_d = 1'b1;
      timeout_d    = 1'b1;
      shot_index_d = BadIndex;
    end

    if (state_d != state_q || ((we_c | re_c) && !bus.wait_request)) begin
      cnt_d = 12'd0;
    end else if (stall) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  // State, counters, result and snapshot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      reg_idx_q    <= 4'd0;
      cnt_q        <= 12'd0;
      wait_cnt_q   <= 2'd0;
      shot_index_q <= 7'd0;
      shot_error_q <= 1'b0;
      timeout_q    <= 1'b0;
      fired_q      <= 100'd0;
      hits_q       <= 100'd0;
      ships_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      reg_idx_q    <= reg_idx_d;
      cnt_q        <= cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      shot_index_q <= shot_index_d;
      shot_error_q <= shot_error_d;
      timeout_q    <= timeout_d;
      if (accept) begin
        fired_q <= fired_in;
        hits_q  <= hits_in;
        ships_q <= ships_in;
      end
    end
  end

  assign bus.addr     = addr_c;
  assign bus.write_en = we_c;
  assign bus.read_en  = re_c;
  assign bus.data_out = wdata_c;

  assign req_ready  = (state_q == StIdle);
  assign shot_valid = (state_q == StDone);
  assign shot_index = shot_index_q;
  assign shot_error = shot_error_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ai_host_master.sv
// Scoreboard bench for ai_host_master with a behavioural accelerator model.
module tb_ai_host_master;

  localparam int unsigned ToCycles = 16;
`ifdef AI_HOST_READBACK_VERIFY_EN
  localparam int VerifyExtra = 9;
`else
  localparam int VerifyExtra = 0;
`endif

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [6:0] idx;
    logic       err;
    logic       to;
    int         lat;
  } res_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [99:0] fired_in;
  logic [99:0] hits_in;
  logic [4:0]  ships_in;
  logic        shot_valid;
  logic [6:0]  shot_index;
  logic        shot_error;
  logic        timeout;

  ai_host_master_if bus_if ();

  ai_host_master #(
    .TIMEOUT_CYCLES (ToCycles),
    .BOARD_CELLS    (100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .fired_in   (fired_in),
    .hits_in    (hits_in),
    .ships_in   (ships_in),
    .shot_valid (shot_valid),
    .shot_index (shot_index),
    .shot_error (shot_error),
    .timeout    (timeout),
    .bus        (bus_if.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- accelerator model ----------------
  logic [31:0] result_val = 32'd0;
  int          busy_cfg   = 0;
  int          stall_cfg  = 0;
  bit          corrupt    = 1'b0;
  int          busy_left  = 0;
  int          stall_left = 0;
  logic [31:0] regs [16];

  assign bus_if.wait_request = (busy_left != 0)
    || (stall_left != 0 && bus_if.write_en && bus_if.addr == 4'd5);

  always_comb begin
    bus_if.data_in = 32'd0;
    if (bus_if.read_en) begin
      if (bus_if.addr == 4'd0) bus_if.data_in = result_val;
      else bus_if.data_in = regs[bus_if.addr] ^ ((corrupt && bus_if.addr == 4'd7) ? 32'h1 : 32'h0);
    end
  end

  always @(posedge clock) begin
    if (req_valid && req_ready) stall_left <= stall_cfg;
    else if (stall_left != 0 && bus_if.write_en && bus_if.addr == 4'd5) stall_left <= stall_left - 1;
    if (shot_valid || reset) busy_left <= 0;
    else if (bus_if.write_en && bus_if.addr == 4'd0 && !bus_if.wait_request) busy_left <= busy_cfg;
    else if (busy_left != 0) busy_left <= busy_left - 1;
    if (bus_if.write_en && !bus_if.wait_request) regs[bus_if.addr] <= bus_if.data_out;
  end

  // ---------------- scoreboard / monitor ----------------
  wr_t  exp_wr [$];
  res_t exp_res [$];
  int   cyc = 0;
  int   acc_cyc, shot_cyc, onset_cyc;
  int   w5_cnt = 0, rd0_cnt = 0;
  bit   in_flight = 1'b0;
  bit   prev_stall = 1'b0;
  logic [3:0]  prev_addr;
  logic [31:0] prev_data;
  logic [1:0]  prev_strb;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      in_flight  = 1'b0;
    end else begin
      if (bus_if.write_en || bus_if.read_en)
        check_eq("one_strobe", 64'(bus_if.write_en & bus_if.read_en), 64'd0);
      if (prev_stall && !shot_valid) begin
        check_eq("hold_addr", 64'(bus_if.addr), 64'(prev_addr));
        check_eq("hold_data", 64'(bus_if.data_out), 64'(prev_data));
        check_eq("hold_strobe", 64'({bus_if.write_en, bus_if.read_en}), 64'(prev_strb));
      end
      if (bus_if.write_en && !bus_if.wait_request) begin
        if (exp_wr.size() == 0) begin
          check_eq("wr_unexpected", 64'(exp_wr.size()), 64'd1);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check_eq("wr_addr", 64'(bus_if.addr), 64'(w.a));
          check_eq("wr_data", 64'(bus_if.data_out), 64'(w.d));
        end
      end
      if (bus_if.write_en && bus_if.addr == 4'd5) w5_cnt++;
      if (bus_if.read_en && bus_if.addr == 4'd0 && !bus_if.wait_request) rd0_cnt++;
      if (bus_if.read_en && bus_if.wait_request && !prev_stall) onset_cyc = cyc;
      if (in_flight) check_eq("rdy_low", 64'(req_ready), 64'd0);
      if (req_valid && req_ready) begin
        acc_cyc   = cyc;
        in_flight = 1'b1;
      end
      if (shot_valid) begin
        shot_cyc  = cyc;
        in_flight = 1'b0;
        if (exp_res.size() == 0) begin
          check_eq("shot_unexpected", 64'(exp_res.size()), 64'd1);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check_eq("shot_index", 64'(shot_index), 64'(r.idx));
          check_eq("shot_error", 64'(shot_error), 64'(r.err));
          check_eq("timeout", 64'(timeout), 64'(r.to));
          check_eq("latency", 64'(cyc - acc_cyc), 64'(r.lat));
        end
      end
      prev_stall = (bus_if.write_en | bus_if.read_en) & bus_if.wait_request;
      prev_addr  = bus_if.addr;
      prev_data  = bus_if.data_out;
      prev_strb  = {bus_if.write_en, bus_if.read_en};
    end
  end

  task automatic push_writes(input logic [99:0] f, input logic [99:0] h, input logic [4:0] s,
                             input bit with_start);
    wr_t w;
    logic [99:0] t;
    for (int k = 0; k < 4; k++) begin
      t = f >> (32 * k);
      w.a = 4'(k + 1);
      w.d = t[31:0];
      exp_wr.push_back(w);
    end
    for (int k = 0; k < 4; k++) begin
      t = h >> (32 * k);
      w.a = 4'(k + 5);
      w.d = t[31:0];
      exp_wr.push_back(w);
    end
    w.a = 4'd9;
    w.d = {27'd0, s};
    exp_wr.push_back(w);
    if (with_start) begin
      w.a = 4'd0;
      w.d = 32'd0;
      exp_wr.push_back(w);
    end
  endtask

  task automatic wait_shot(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (shot_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // busy: cycles the model holds wait_request after start (0 = never raises).
  task automatic run_req(input logic [99:0] f, input logic [99:0] h, input logic [4:0] s,
                         input logic [31:0] res, input int busy, input int stall,
                         input bit corrupt7, input bit expect_to);
    res_t r;
    bit   seen;
    bit   hit;
    int   rd0_start, w5_start;
    hit = 1'b0;
    if (res[6:0] < 7'd100) hit = f[res[6:0]];
    r.to  = 1'b0;
    r.err = 1'b0;
    r.idx = res[6:0];
    if (expect_to) begin
      r.err = 1'b1;
      r.to  = 1'b1;
      r.idx = 7'h7F;
      r.lat = 12 + ToCycles + stall + VerifyExtra;
    end else if (corrupt7) begin
      r.err = 1'b1;
      r.idx = 7'h7F;
      r.lat = 17 + stall;
    end else begin
      if (res[31:7] != 25'd0 || res[6:0] > 7'd99 || hit) begin
        r.err = 1'b1;
        r.idx = 7'h7F;
      end
      r.lat = ((busy == 0) ? 16 : 12 + busy) + stall + VerifyExtra;
    end
    exp_res.push_back(r);
    push_writes(f, h, s, !corrupt7);
    result_val = res;
    busy_cfg   = busy;
    stall_cfg  = stall;
    corrupt    = corrupt7;
    fired_in   = f;
    hits_in    = h;
    ships_in   = s;
    rd0_start  = rd0_cnt;
    w5_start   = w5_cnt;
    req_valid  = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_shot(seen);
    check_eq("shot_seen", 64'(seen), 64'd1);
    @(negedge clock);
    check_eq("rdy_after", 64'(req_ready), 64'd1);
    check_eq("wr_left", 64'(exp_wr.size()), 64'd0);
    check_eq("rd0_count", 64'(rd0_cnt - rd0_start), 64'((corrupt7 || expect_to) ? 0 : 1));
    if (stall > 0) check_eq("w5_cycles", 64'(w5_cnt - w5_start), 64'(stall + 1));
    exp_wr.delete();
    exp_res.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [127:0] rnd;
    logic [99:0]  f, h;
    bit           seen;
    int           nshot;

    reset     = 1'b1;
    req_valid = 1'b0;
    fired_in  = '0;
    hits_in   = '0;
    ships_in  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_valid", 64'(shot_valid), 64'd0);
    check_eq("rst_index", 64'(shot_index), 64'd0);
    check_eq("rst_strobes", 64'({bus_if.write_en, bus_if.read_en}), 64'd0);
    check_eq("rst_addr", 64'(bus_if.addr), 64'd0);
    check_eq("rst_data", 64'(bus_if.data_out), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic run, accelerator busy one cycle: 13-cycle latency.
    run_req('0, '0, 5'h1F, 32'd44, 1, 0, 1'b0, 1'b0);
    // Accelerator never raises busy: 4-cycle fallback.
    f = '0;
    f[3] = 1'b1;
    f[99] = 1'b1;
    run_req(f, {4'hA, 96'h0}, 5'h0B, 32'd57, 0, 0, 1'b0, 1'b0);
    // Stall the reg-5 write for 3 cycles.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    h = rnd[99:0];
    run_req('0, h, 5'h15, 32'd3, 3, 3, 1'b0, 1'b0);
    // Invalid indices.
    run_req('0, '0, 5'h1F, 32'd100, 1, 0, 1'b0, 1'b0);
    f = '0;
    f[12] = 1'b1;
    run_req(f, '0, 5'h1F, 32'd12, 1, 0, 1'b0, 1'b0);
    run_req('0, '0, 5'h1F, 32'h0000_0085, 2, 0, 1'b0, 1'b0);
    run_req('0, '0, 5'h1F, 32'd99, 1, 0, 1'b0, 1'b0);
    // Timeout with wait_request stuck after start.
    run_req('0, '0, 5'h1F, 32'd7, 1000, 0, 1'b0, 1'b1);
    check_eq("to_onset", 64'(shot_cyc - onset_cyc), 64'(ToCycles));

    // Reset during WAIT_BUSY.
    push_writes('0, '0, 5'h03, 1'b1);
    fired_in  = '0;
    hits_in   = '0;
    ships_in  = 5'h03;
    busy_cfg  = 0;
    stall_cfg = 0;
    corrupt   = 1'b0;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (bus_if.write_en && bus_if.addr == 4'd0 && !bus_if.wait_request) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("start_seen", 64'(seen), 64'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_strobes", 64'({bus_if.write_en, bus_if.read_en}), 64'd0);
    check_eq("mid_rst_ready", 64'(req_ready), 64'd1);
    check_eq("mid_rst_error", 64'(shot_error), 64'd0);
    check_eq("mid_rst_index", 64'(shot_index), 64'd0);
    nshot = 0;
    for (int k = 0; k < 10; k++) begin
      if (shot_valid) nshot++;
      @(negedge clock);
    end
    check_eq("mid_rst_noshot", 64'(nshot), 64'd0);
    check_eq("mid_rst_wr_left", 64'(exp_wr.size()), 64'd0);
    exp_wr.delete();
    @(posedge clock);
    #1;
    run_req('0, '0, 5'h1F, 32'd21, 1, 0, 1'b0, 1'b0);

    // A few random snapshots and results.
    for (int n = 0; n < 4; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      f = rnd[99:0];
      rnd = {$urandom, $urandom, $urandom, $urandom};
      h = rnd[99:0];
      run_req(f, h, 5'($urandom), 32'($urandom_range(0, 127)), $urandom_range(0, 3), 0,
              1'b0, 1'b0);
    end

`ifdef AI_HOST_READBACK_VERIFY_EN
    // Corrupt readback of reg 7: no start write, error without timeout.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    h = rnd[99:0];
    run_req('0, h, 5'h1F, 32'd5, 1, 0, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
